// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter.
// Holds the FSM state encoding, the port index constants used by the
// round-robin pointer, and default bus widths for the 16x8 RAM.
package ram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W = 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [1:0] CLEAR  = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = IDLE,
    StAccess = ACCESS,
    StResp   = RESP,
    StClear  = CLEAR
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM.
// slave  : arbiter view (takes requests and RAM read data, drives grants,
//          completions, read data and the RAM control/data lines).
// master : requester/RAM view, the mirror image of slave.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  // Port A (CPU)
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_done;
  logic [DATA_W-1:0] a_rdata;

  // Port B (front panel / loader)
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_done;
  logic [DATA_W-1:0] b_rdata;
  logic              b_clear_req;
  logic              b_clear_done;

  // RAM side
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_write_enable;
  logic              ram_reset;
  logic [DATA_W-1:0] ram_data_out;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata, b_clear_req,
    input  ram_data_out,
    output a_gnt, a_done, a_rdata,
    output b_gnt, b_done, b_rdata, b_clear_done,
    output ram_address, ram_data_in, ram_write_enable, ram_reset
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata, b_clear_req,
    output ram_data_out,
    input  a_gnt, a_done, a_rdata,
    input  b_gnt, b_done, b_rdata, b_clear_done,
    input  ram_address, ram_data_in, ram_write_enable, ram_reset
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// req_a, req_b : requests from port A / port B
// last         : most recent winner (PORT_A or PORT_B)
// gnt          : one-hot grant, bit 0 = A, bit 1 = B; zero when no request
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req_a && req_b) begin
      // On a tie the port that did not win last time goes next.
      gnt = (last == PORT_B) ? 2'b01 : 2'b10;
    end else if (req_a) begin
      gnt = 2'b01;
    end else if (req_b) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter and access sequencer for the 16x8 RAM.
// Every access runs IDLE -> ACCESS -> RESP -> IDLE so the RAM's registered
// read latency is absorbed; port B may also request a full clear, which
// takes IDLE -> CLEAR -> IDLE and has priority over both access requests.
// clk     : system clock, rising edge
// reset_n : synchronous active-low reset
// bus     : ram_arbiter_if.slave (requests, grants, completions, RAM lines)
// All outputs are registered.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         reset_n,
  ram_arbiter_if.slave bus
);

  state_e            state_q;
  logic              last_q;
  logic              win_q;    // port that owns the access in flight
  logic              we_q;     // in-flight access is a write
  logic              a_gnt_q, b_gnt_q, a_done_q, b_done_q, clear_done_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q;
  logic              ram_we_q, ram_reset_q;

  logic [1:0]        pick;
  logic              sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req_a (bus.a_req),
    .req_b (bus.b_req),
    .last  (last_q),
    .gnt   (pick)
  );

  always_comb begin
    sel_port  = pick[1] ? PORT_B : PORT_A;
    sel_we    = pick[1] ? bus.b_we    : bus.a_we;
    sel_addr  = pick[1] ? bus.b_addr  : bus.a_addr;
    sel_wdata = pick[1] ? bus.b_wdata : bus.a_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_q       <= PORT_B;
      win_q        <= PORT_A;
      we_q         <= 1'b0;
      a_gnt_q      <= 1'b0;
      b_gnt_q      <= 1'b0;
      a_done_q     <= 1'b0;
      b_done_q     <= 1'b0;
      clear_done_q <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_we_q     <= 1'b0;
      ram_reset_q  <= 1'b0;
    end else begin
      // Grant and completion strobes are single-cycle pulses.
      a_gnt_q      <= 1'b0;
      b_gnt_q      <= 1'b0;
      a_done_q     <= 1'b0;
      b_done_q     <= 1'b0;
      clear_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.b_clear_req) begin
            ram_reset_q <= 1'b1;
            state_q     <= StClear;
          end else if (|pick) begin
            win_q      <= sel_port;
            last_q     <= sel_port;
            we_q       <= sel_we;
            ram_we_q   <= sel_we;
            ram_addr_q <= sel_addr;
            ram_din_q  <= sel_wdata;
            if (sel_port == PORT_A) begin
              a_gnt_q <= 1'b1;
            end else begin
              b_gnt_q <= 1'b1;
            end
            state_q <= StAccess;
          end
        end
        StAccess: begin
          // The RAM performs the access at this edge.
          ram_we_q <= 1'b0;
          state_q  <= StResp;
        end
        StResp: begin
          // Writes leave the requester's read data untouched.
          if (win_q == PORT_A) begin
            if (!we_q) a_rdata_q <= bus.ram_data_out;
            a_done_q <= 1'b1;
          end else begin
            if (!we_q) b_rdata_q <= bus.ram_data_out;
            b_done_q <= 1'b1;
          end
          state_q <= StIdle;
        end
        StClear: begin
          ram_reset_q  <= 1'b0;
          clear_done_q <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.a_gnt            = a_gnt_q;
  assign bus.b_gnt            = b_gnt_q;
  assign bus.a_done           = a_done_q;
  assign bus.b_done           = b_done_q;
  assign bus.a_rdata          = a_rdata_q;
  assign bus.b_rdata          = b_rdata_q;
  assign bus.b_clear_done     = clear_done_q;
  assign bus.ram_address      = ram_addr_q;
  assign bus.ram_data_in      = ram_din_q;
  assign bus.ram_write_enable = ram_we_q;
  assign bus.ram_reset        = ram_reset_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural 16x8 RAM
// (registered read, synchronous clear). Expected read data is pushed to a
// per-port scoreboard when a request is driven and popped on each done.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  ram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural RAM: loads a known pattern on its first edge.
  logic [7:0] ram_mem [16];
  bit         ram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= 8'(i ^ 10);
      ram_init_done <= 1'b1;
      bus.ram_data_out <= '0;
    end else if (bus.ram_reset) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= '0;
      bus.ram_data_out <= '0;
    end else begin
      if (bus.ram_write_enable) ram_mem[bus.ram_address] <= bus.ram_data_in;
      bus.ram_data_out <= ram_mem[bus.ram_address];
    end
  end

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Bench model
  logic [7:0] model_mem [16];
  logic [7:0] held [2];
  logic       exp_last;
  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];
  logic       gnt_log[$];
  int         gnt_cyc_log[$];
  int         a_gnt_cyc = 0;
  int         b_gnt_cyc = 0;

  task automatic push_exp(input logic port, input logic we, input logic [3:0] addr,
                          input logic [7:0] wdata);
    if (we) model_mem[addr] = wdata;
    else held[port] = model_mem[addr];
    if (port == PORT_A) sb_a.push_back(held[port]);
    else sb_b.push_back(held[port]);
  endtask

  // Done/grant monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.a_gnt && bus.b_gnt) check("gnt_onehot", 2'b11, 2'b01);
      if (bus.a_gnt) begin
        a_gnt_cyc = cyc;
        gnt_log.push_back(PORT_A);
        gnt_cyc_log.push_back(cyc);
      end
      if (bus.b_gnt) begin
        b_gnt_cyc = cyc;
        gnt_log.push_back(PORT_B);
        gnt_cyc_log.push_back(cyc);
      end
      if (bus.a_done) begin
        if (sb_a.size() == 0) check("a_done_unexpected", bus.a_done, 1'b0);
        else begin
          check("a_rdata", bus.a_rdata, sb_a.pop_front());
          check("a_done_latency", cyc - a_gnt_cyc, 2);
        end
      end
      if (bus.b_done) begin
        if (sb_b.size() == 0) check("b_done_unexpected", bus.b_done, 1'b0);
        else begin
          check("b_rdata", bus.b_rdata, sb_b.pop_front());
          check("b_done_latency", cyc - b_gnt_cyc, 2);
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_a_gnt"}, bus.a_gnt, 0);
    check({tag, "_b_gnt"}, bus.b_gnt, 0);
    check({tag, "_a_done"}, bus.a_done, 0);
    check({tag, "_b_done"}, bus.b_done, 0);
    check({tag, "_clr_done"}, bus.b_clear_done, 0);
    check({tag, "_ram_we"}, bus.ram_write_enable, 0);
    check({tag, "_ram_reset"}, bus.ram_reset, 0);
    check({tag, "_ram_addr"}, bus.ram_address, 0);
    check({tag, "_ram_din"}, bus.ram_data_in, 0);
    check({tag, "_a_rdata"}, bus.a_rdata, 0);
    check({tag, "_b_rdata"}, bus.b_rdata, 0);
  endtask

  // Single uncontended access, entered and left on a falling edge.
  task automatic access(input logic port, input logic we, input logic [3:0] addr,
                        input logic [7:0] wdata);
    int waited;
    bit seen;
    push_exp(port, we, addr, wdata);
    if (port == PORT_A) begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end else begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < 10) begin
      @(negedge clk);
      waited++;
      seen = (port == PORT_A) ? bus.a_gnt : bus.b_gnt;
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    check("gnt_latency", waited, 1);
    check("acc_we", bus.ram_write_enable, we);
    check("acc_addr", bus.ram_address, addr);
    if (we) check("acc_wdata", bus.ram_data_in, wdata);
    exp_last = port;
    @(negedge clk);
    check("we_dropped", bus.ram_write_enable, 0);
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < 10) begin
      @(negedge clk);
      waited++;
      seen = (port == PORT_A) ? bus.a_done : bus.b_done;
    end
    check("done_seen", seen, 1);
  endtask

  task automatic drain(input string tag);
    int waited = 0;
    while ((sb_a.size() != 0 || sb_b.size() != 0) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check(tag, sb_a.size() + sb_b.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic first;
    int   waited;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    bus.b_clear_req = 0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'(i ^ 10);
    held[0] = '0;
    held[1] = '0;
    exp_last = PORT_B;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Single read: addr 9 holds 0x03.
    access(PORT_A, 1'b0, 4'd9, 8'h00);
    // Write then read back on B.
    access(PORT_B, 1'b1, 4'd14, 8'hA5);
    access(PORT_B, 1'b0, 4'd14, 8'h00);
    // Hold: read 0x01, then a write leaves a_rdata at 0x01.
    access(PORT_A, 1'b0, 4'd11, 8'h00);
    access(PORT_A, 1'b1, 4'd11, 8'h77);

    // Contention: both ports held for four grants.
    gnt_log.delete();
    gnt_cyc_log.delete();
    first = (exp_last == PORT_B) ? PORT_A : PORT_B;
    push_exp(PORT_A, 1'b0, 4'd3, 8'h00);
    push_exp(PORT_A, 1'b0, 4'd3, 8'h00);
    push_exp(PORT_B, 1'b0, 4'd7, 8'h00);
    push_exp(PORT_B, 1'b0, 4'd7, 8'h00);
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 4'd3;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 4'd7;
    waited = 0;
    while (gnt_log.size() < 4 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    bus.a_req = 0;
    bus.b_req = 0;
    check("rr_count", gnt_log.size(), 4);
    for (int k = 0; k < gnt_log.size() && k < 4; k++) begin
      check("rr_order", gnt_log[k], first ^ k[0]);
      if (k > 0) check("rr_spacing", gnt_cyc_log[k] - gnt_cyc_log[k-1], 3);
    end
    exp_last = first ^ 1'b1;
    drain("rr_drain");

    // Clear has priority over a simultaneous A read of addr 0.
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    push_exp(PORT_A, 1'b0, 4'd0, 8'h00);
    bus.b_clear_req = 1;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 4'd0;
    @(negedge clk);
    check("clr_reset_hi", bus.ram_reset, 1);
    check("clr_no_gnt", bus.a_gnt, 0);
    bus.b_clear_req = 0;
    @(negedge clk);
    check("clr_reset_lo", bus.ram_reset, 0);
    check("clr_done", bus.b_clear_done, 1);
    @(negedge clk);
    check("clr_then_a", bus.a_gnt, 1);
    bus.a_req = 0;
    exp_last = PORT_A;
    drain("clr_drain");
    access(PORT_B, 1'b0, 4'd14, 8'h00);

    // Reset at the edge closing ACCESS of an A write.
    push_exp(PORT_A, 1'b1, 4'd15, 8'h5A);
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 4'd15; bus.a_wdata = 8'h5A;
    @(negedge clk);
    check("rst_gnt", bus.a_gnt, 1);
    bus.a_req = 0;
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    sb_a.delete();
    held[0] = '0;
    held[1] = '0;
    exp_last = PORT_B;
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_no_done", bus.a_done, 0);
    end
    access(PORT_A, 1'b0, 4'd15, 8'h00);

    repeat (2) @(negedge clk);
    check("sb_a_empty", sb_a.size(), 0);
    check("sb_b_empty", sb_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and access sequencer for the 16×8 RAM. It shares the RAM between the CPU (port A) and the front-panel/program loader (port B) using round-robin arbitration. Each access runs through a fixed three-state sequence that absorbs the RAM's registered read latency. Port B can also request a full RAM clear, which is issued through the RAM's active-high clear input.

## Interface
Parameters:
- ADDR_W, 4, address width; the RAM depth is 2^ADDR_W.
- DATA_W, 8, data width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous reset, active-low. One clock; reset is synchronous and active-low.
- a_req / b_req  in  1  access request, level-sensitive.
- a_we / b_we  in  1  1 = write, 0 = read. Sampled with req.
- a_addr / b_addr  in  ADDR_W  access address.
- a_wdata / b_wdata  in  DATA_W  write data.
- a_gnt / b_gnt  out  1  one-cycle pulse: the request was accepted and the requester's inputs may change.
- a_done / b_done  out  1  one-cycle pulse: the access is complete.
- a_rdata / b_rdata  out  DATA_W  read data. Valid while done is high; otherwise held.
- b_clear_req  in  1  request to clear the whole RAM.
- b_clear_done  out  1  one-cycle pulse after the clear is issued.
- ram_address  out  ADDR_W  drives the RAM address input.
- ram_data_in  out  DATA_W  drives the RAM data input.
- ram_write_enable  out  1  drives the RAM write enable.
- ram_reset  out  1  drives the RAM clear input (active-high).
- ram_data_out  in  DATA_W  RAM registered read data.

## Operation
- **FSM states:** IDLE, ACCESS, RESP, CLEAR. All outputs are registered.
- **IDLE:**
  - b_clear_req=1 → CLEAR. Clear has priority over both reqs.
  - Otherwise, if any req is high, pick a winner, latch its we/addr/wdata into the ram_* registers, pulse its gnt, and go to ACCESS.
  - Otherwise stay in IDLE with ram_write_enable=0.
- **ACCESS:** ram_* outputs hold the latched access. The RAM performs it at the closing edge. Go to RESP. ram_write_enable drops to 0 on leaving ACCESS.
- **RESP:** ram_data_out holds the read result. At the closing edge:
  - for a read, the winner's rdata ← ram_data_out; for a write, rdata is unchanged;
  - pulse the winner's done;
  - go to IDLE.
- **CLEAR:** ram_reset=1 for exactly this one cycle, so the RAM zeroes all 16 words at its closing edge. Then pulse b_clear_done and go to IDLE.
- **Round-robin:** a `last` pointer records the most recent winner. On a tie, the port that is not `last` wins. `last` resets to B, so A wins the first tie. A single requester always wins regardless of `last`.
- **Request sampling:** req is sampled only in IDLE. A requester holding req high across done is re-arbitrated in the following IDLE cycle.
- **Address range:** all ADDR_W address values are legal. There is no wrap or bounds logic.

## Timing
- **Access latency** (req high at an IDLE edge, edge 0):
  - gnt is high in cycle 1 (ACCESS).
  - The RAM samples at edge 1.
  - rdata and done are valid in cycle 3, which is the next IDLE cycle.
- **Throughput:** one access per 3 cycles. The edge that ends the done cycle may accept the next request.
- **Clear latency:** b_clear_req at edge 0 → ram_reset high in cycle 1 → b_clear_done in cycle 2.
- **Reset values:**
  - state = IDLE;
  - all gnt and done pulses = 0, b_clear_done = 0;
  - ram_write_enable = 0, ram_reset = 0;
  - ram_address, ram_data_in, a_rdata, b_rdata = 0;
  - last = B.
- **Reset mid-operation:**
  - reset_n low at the edge closing ACCESS: the RAM still performs that access, because it samples the pre-reset registers. No done pulse follows.
  - reset_n low during CLEAR: the clear still completes. No b_clear_done follows.
- **Simultaneous events:**
  - a_req, b_req and b_clear_req together → CLEAR first, then the round-robin winner.
  - Both reqs together → alternation A, B, A, …

## Structure
- **Package ram_arb_pkg:** state encoding localparams (IDLE, ACCESS, RESP, CLEAR), port index constants PORT_A and PORT_B, and ADDR_W/DATA_W defaults.
- **Sub-module rr_pick2:** a combinational two-way round-robin picker. Inputs are req_a, req_b and last; outputs are a one-hot grant. The FSM, latching and response routing stay in ram_arbiter.

## Test plan
- **Single read:** after reset, a_req=1, a_we=0, a_addr=9 with the RAM holding 0x03 → a_gnt in cycle 1, a_done in cycle 3, a_rdata=0x03.
- **Write then read:** b writes 0xA5 to addr 14, then b reads addr 14 → first b_done at cycle 3, second b_rdata=0xA5 at cycle 6. ram_write_enable is high only in the first ACCESS cycle.
- **Contention:** a_req and b_req held high for 4 grants → grant order A, B, A, B, each 3 cycles apart. rdata for each port matches its own address.
- **Clear priority:** b_clear_req and a_req asserted together → ram_reset high for one cycle, then b_clear_done, then the A access. A read of addr 0 returns 0x00.
- **Reset during write:** reset_n low at the edge ending ACCESS of an A write (0x5A to addr 15) → no a_done, all outputs at reset values. A later read of addr 15 returns 0x5A.
- **Hold behaviour:** after an A read returns 0x01, an A write → a_rdata stays 0x01 through the write's done.
